lsu_byte_sequencer: RTL and testbench
=====================================

# lsu_byte_sequencer

Multi-cycle load/store sequencer between the execute stage and the byte-addressed, big-endian data memory. Accepts one byte, halfword or word request through a valid/ready handshake. Issues it to the memory as consecutive single-byte accesses, most significant byte first at the lowest address. Returns load data sign- or zero-extended to 32 bits with a one-cycle response strobe.

## Interface
- `ADDR_W`, default 32: address width of request and memory side.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces all registers to reset values immediately.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; request accepted on a rising edge with `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: size code: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in ADDR_W: byte address of the most significant byte.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse when the request completes.
- `resp_err` out 1: valid with `resp_valid`; request rejected, no memory access made.
- `resp_rdata` out 32: load result; 0 for stores and errors; holds until the next response.
- `mem_addr` out ADDR_W: byte address to the memory.
- `mem_wdata` out 8: byte to write.
- `mem_write` out 1: byte write strobe; memory writes on the rising edge.
- `mem_read` out 1: byte read strobe.
- `mem_rdata` in 8: combinational read data for `mem_addr`.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, request accepted:
  - Latch write, size, unsigned, address and data.
  - Clear the byte index and the assembly register.
  - Next state is ACCESS if the request is legal; otherwise DONE with error.
- Byte count N: byte = 1, half = 2, word = 4. Size 11 is always illegal.
- ACCESS, cycle k (k = 0..N-1):
  - `mem_addr` = base + k, modulo 2^ADDR_W. Wrap from all-ones to 0 is legal.
  - Load: `mem_read` = 1. Shift `mem_rdata` into the assembly register at the edge.
  - Store: `mem_write` = 1; `mem_wdata` = `req_wdata` byte (N-1-k).
    - Byte store: `[7:0]`.
    - Half store: `[15:8]` then `[7:0]`.
    - Word store: `[31:24]` first.
  - After byte N-1, go to DONE.
- DONE:
  - `resp_valid` = 1 for exactly one cycle, then IDLE.
  - Load result: byte bit 7 or half bit 15 extends per `req_unsigned`; a word loads unchanged.
- Outside ACCESS: `mem_read`, `mem_write`, `mem_wdata` and `mem_addr` are 0. Strobes are decoded from state, never both high.
- `req_*` inputs are ignored outside IDLE.
- Reset mid-operation: return to IDLE at once and drop strobes. Bytes already written stay written; no response is issued.

## Timing
- Reset values:
  - State IDLE, so `req_ready` = 1.
  - `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0.
  - All `mem_*` outputs 0.
- Accept at edge E0. ACCESS occupies cycles 1..N. DONE (response) is at cycle N+1. The next request can be accepted at the edge ending cycle N+2, which is IDLE.
- Word request: 6 cycles from accept to next accept.
- Error request: response in cycle 1, zero memory strobes.
- Back-to-back `req_valid` is held off by `req_ready` = 0; there is no queueing.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Illegal requests are a half with `addr[0]`=1, a word with `addr[1:0]`≠0, or size 11.
  - All three take the error path.
- Not defined:
  - Only size 11 is an error.
  - Misaligned half/word requests run byte-serially like aligned ones, with identical latency.

## Test plan
- Reset held, then released:
  - `req_ready` = 1 and all other outputs 0.
  - Assert `reset` mid-word-store after 2 bytes. Memory shows only bytes 0–1 changed, no `resp_valid`, `req_ready` = 1 on the next cycle.
- Word store, addr 0x10, data 0xA1B2C3D4:
  - mem bytes 0x10..0x13 = A1, B2, C3, D4.
  - `resp_valid` at cycle 5, `resp_rdata` = 0.
- Loads with mem 0x20 = 0x80, 0x21 = 0x7F:
  - Signed byte load at 0x20 gives 0xFFFFFF80; unsigned gives 0x00000080.
  - Signed half load at 0x20 gives 0xFFFF807F.
- Word load at address 0xFFFFFFFE:
  - `mem_addr` sequence is FFFFFFFE, FFFFFFFF, 0, 1 (tests with macro undefined).
- Half load at addr 0x31:
  - Macro defined: `resp_err` = 1 in cycle 1, no strobes.
  - Macro undefined: result is {0x31, 0x32} bytes, `resp_err` = 0.
- Size 11 request: `resp_err` = 1, `resp_rdata` = 0, no strobes, in both builds.

Source files
------------

// File: rtl/lsu_byte_sequencer_if.sv
// Purpose : bundles the request, response and byte-memory signals of lsu_byte_sequencer.
// Ports   : req_* / resp_* toward the execute stage, mem_* toward the byte-wide data memory.
// Modports: slave = sequencer; master = execute stage plus memory (drives req_* and mem_rdata).
interface lsu_byte_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output mem_addr, mem_wdata, mem_write, mem_read
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  mem_addr, mem_wdata, mem_write, mem_read
   );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Purpose : serialises one byte/half/word load or store into single-byte big-endian memory
//           accesses (MSB at lowest address) and returns sign/zero-extended load data.
// Ports   : clock, reset (async, active-high), bus (lsu_byte_sequencer_if.slave).
// Latency : accept edge, then N access cycles, then a one-cycle response; errors respond in cycle 1.
// Backpressure: req_ready is high only in IDLE, so no request is queued.
// Option  : define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests as errors.
module lsu_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   lsu_byte_sequencer_if.slave   bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]        state_q,  state_d;
   logic              write_q,  write_d;
   logic [1:0]        size_q,   size_d;
   logic              uns_q,    uns_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic [1:0]        idx_q,    idx_d;
   logic [31:0]       asm_q,    asm_d;
   logic              err_q,    err_d;
   logic [31:0]       rdata_q,  rdata_d;

   logic       in_access;
   logic [1:0] last_idx;
   logic [1:0] byte_sel;
   logic       req_legal;

   // Index of the final byte: byte 0, half 1, word 3.
   always_comb begin
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      case (bus.req_size)
         2'b00:   req_legal = 1'b1;
         2'b01:   req_legal = ~bus.req_addr[0];
         2'b10:   req_legal = (bus.req_addr[1:0] == 2'b00);
         default: req_legal = 1'b0;
      endcase
`else
      req_legal = (bus.req_size != 2'b11);
`endif
   end

   function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz,
                                          input logic uns);
      logic [31:0] r;
      case (sz)
         2'b00:   r = uns ? {24'h0, a[7:0]}  : {{24{a[7]}},  a[7:0]};
         2'b01:   r = uns ? {16'h0, a[15:0]} : {{16{a[15]}}, a[15:0]};
         default: r = a;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               idx_d   = 2'd0;
               asm_d   = 32'h0;
               if (req_legal) begin
                  err_d   = 1'b0;
                  state_d = ST_ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACCESS: begin
            // Big-endian: earlier bytes shift up as later ones arrive.
            if (!write_q) begin
               asm_d = {asm_q[23:0], bus.mem_rdata};
            end
            if (idx_q == last_idx) begin
               rdata_d = write_q ? 32'h0 : extend(asm_d, size_q, uns_q);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         idx_q   <= 2'd0;
         asm_q   <= 32'h0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_access = (state_q == ST_ACCESS);
   // Store data is right-justified, so the first byte sent is the highest used lane.
   assign byte_sel  = last_idx - idx_q;

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_DONE);
   assign bus.resp_err   = (state_q == ST_DONE) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.mem_read   = in_access && !write_q;
   assign bus.mem_write  = in_access && write_q;
   assign bus.mem_addr   = in_access ? (addr_q + ADDR_W'(idx_q)) : '0;
   assign bus.mem_wdata  = in_access ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;
   localparam int ADDR_W = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   lsu_byte_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

   lsu_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   // Byte memory model: 256 bytes addressed by mem_addr[7:0].
   logic [7:0] mem [0:255];
   logic       mem_load;

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         8'h20:   return 8'h80;
         8'h21:   return 8'h7F;
         8'h31:   return 8'h9A;
         8'h32:   return 8'hBC;
         8'hFE:   return 8'h11;
         8'hFF:   return 8'h22;
         8'h00:   return 8'h33;
         8'h01:   return 8'h44;
         default: return 8'h00;
      endcase
   endfunction

   int          rd_cnt, wr_cnt, resp_cnt, both_cnt, log_n;
   logic [31:0] addr_log [0:63];

   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
         rd_cnt <= 0; wr_cnt <= 0; resp_cnt <= 0; both_cnt <= 0; log_n <= 0;
      end else begin
         if (bus_if.mem_write) mem[bus_if.mem_addr[7:0]] <= bus_if.mem_wdata;
         if (bus_if.mem_read)  rd_cnt <= rd_cnt + 1;
         if (bus_if.mem_write) wr_cnt <= wr_cnt + 1;
         if (bus_if.mem_read && bus_if.mem_write) both_cnt <= both_cnt + 1;
         if (bus_if.resp_valid) resp_cnt <= resp_cnt + 1;
         if (bus_if.mem_read || bus_if.mem_write) begin
            if (log_n < 64) addr_log[log_n] <= bus_if.mem_addr;
            log_n <= log_n + 1;
         end
      end
   end

   assign bus_if.mem_rdata = mem[bus_if.mem_addr[7:0]];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata);
      vec_t v;
      v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.err = err; v.rdata = rdata;
      return v;
   endfunction

   // Issue one request and check latency, response and strobe counts.
   task automatic run_req(input vec_t v, input string nm);
      int          rd0, wr0, resp0, nb, lat, exp_lat;
      logic        got_err;
      logic [31:0] got_rdata;
      @(negedge clock);
      rd0 = rd_cnt; wr0 = wr_cnt; resp0 = resp_cnt;
      nb  = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
      exp_lat = v.err ? 1 : nb + 1;
      chk({nm, " ready_before"}, {31'h0, bus_if.req_ready}, 32'h1);
      bus_if.req_valid    = 1'b1;
      bus_if.req_write    = v.wr;
      bus_if.req_size     = v.size;
      bus_if.req_unsigned = v.uns;
      bus_if.req_addr     = v.addr;
      bus_if.req_wdata    = v.wdata;
      @(posedge clock);
      #1 bus_if.req_valid = 1'b0;
      lat = 0; got_err = 1'b0; got_rdata = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (bus_if.resp_valid) begin
            lat = c; got_err = bus_if.resp_err; got_rdata = bus_if.resp_rdata;
            break;
         end
      end
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " resp_err"}, {31'h0, got_err}, {31'h0, v.err});
      chk({nm, " resp_rdata"}, got_rdata, v.rdata);
      chk({nm, " reads"}, rd_cnt - rd0, (!v.wr && !v.err) ? nb : 0);
      chk({nm, " writes"}, wr_cnt - wr0, (v.wr && !v.err) ? nb : 0);
      @(negedge clock);
      chk({nm, " pulse_one_cycle"}, {31'h0, bus_if.resp_valid}, 32'h0);
      chk({nm, " ready_after"}, {31'h0, bus_if.req_ready}, 32'h1);
      chk({nm, " resp_count"}, resp_cnt - resp0, 1);
   endtask

   vec_t vecs [15];
   vec_t wv;
   int   log0, resp0;

   initial begin
      //            wr    size   uns   addr          wdata         err   rdata
      vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,       32'hA1B2C3D4, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 2'b00, 1'b0, 32'h20,       32'h0,        1'b0, 32'hFFFFFF80);
      vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h20,       32'h0,        1'b0, 32'h00000080);
      vecs[3]  = mk(1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        1'b0, 32'hFFFF807F);
      vecs[4]  = mk(1'b0, 2'b01, 1'b1, 32'h20,       32'h0,        1'b0, 32'h0000807F);
      vecs[5]  = mk(1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        1'b0, 32'h0000007F);
      vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        1'b0, 32'hA1B2C3D4);
      vecs[7]  = mk(1'b0, 2'b11, 1'b0, 32'h20,       32'h0,        1'b1, 32'h0);
      vecs[8]  = mk(1'b1, 2'b11, 1'b0, 32'h24,       32'hFFFFFFFF, 1'b1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[9]  = mk(1'b0, 2'b01, 1'b0, 32'h31,       32'h0,        1'b1, 32'h0);
      vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h21,       32'h0,        1'b1, 32'h0);
`else
      vecs[9]  = mk(1'b0, 2'b01, 1'b0, 32'h31,       32'h0,        1'b0, 32'hFFFF9ABC);
      vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h21,       32'h0,        1'b0, 32'h7F000000);
`endif
      vecs[11] = mk(1'b1, 2'b01, 1'b0, 32'h40,       32'h12345678, 1'b0, 32'h0);
      vecs[12] = mk(1'b0, 2'b01, 1'b1, 32'h40,       32'h0,        1'b0, 32'h00005678);
      vecs[13] = mk(1'b1, 2'b00, 1'b0, 32'h50,       32'hAABBCCEE, 1'b0, 32'h0);
      vecs[14] = mk(1'b0, 2'b00, 1'b0, 32'h50,       32'h0,        1'b0, 32'hFFFFFFEE);

      bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'b00;
      bus_if.req_unsigned = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = 32'h0;
      reset = 1'b1; mem_load = 1'b1;
      @(posedge clock);
      @(negedge clock);
      mem_load = 1'b0;
      chk("rst req_ready",  {31'h0, bus_if.req_ready},  32'h1);
      chk("rst resp_valid", {31'h0, bus_if.resp_valid}, 32'h0);
      chk("rst resp_err",   {31'h0, bus_if.resp_err},   32'h0);
      chk("rst resp_rdata", bus_if.resp_rdata, 32'h0);
      chk("rst mem_strobes", {30'h0, bus_if.mem_read, bus_if.mem_write}, 32'h0);
      chk("rst mem_addr",   bus_if.mem_addr, 32'h0);
      chk("rst mem_wdata",  {24'h0, bus_if.mem_wdata}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) run_req(vecs[i], $sformatf("vec%0d", i));

      // Load result holds in IDLE until the next response.
      @(negedge clock);
      chk("rdata_hold", bus_if.resp_rdata, 32'hFFFFFFEE);
      chk("mem10", {24'h0, mem[8'h10]}, 32'hA1);
      chk("mem11", {24'h0, mem[8'h11]}, 32'hB2);
      chk("mem12", {24'h0, mem[8'h12]}, 32'hC3);
      chk("mem13", {24'h0, mem[8'h13]}, 32'hD4);
      chk("mem24_untouched", {24'h0, mem[8'h24]}, 32'h00);
      chk("mem40", {24'h0, mem[8'h40]}, 32'h56);
      chk("mem41", {24'h0, mem[8'h41]}, 32'h78);
      chk("mem50", {24'h0, mem[8'h50]}, 32'hEE);

      // Word load across the top of the address space.
      log0 = log_n;
`ifdef LSU_MISALIGN_TRAP_EN
      run_req(mk(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0), "wrap");
`else
      run_req(mk(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h11223344), "wrap");
      chk("wrap addr0", addr_log[log0],     32'hFFFFFFFE);
      chk("wrap addr1", addr_log[log0 + 1], 32'hFFFFFFFF);
      chk("wrap addr2", addr_log[log0 + 2], 32'h00000000);
      chk("wrap addr3", addr_log[log0 + 3], 32'h00000001);
`endif

      // Reset after two bytes of a word store.
      @(negedge clock);
      resp0 = resp_cnt;
      wv = mk(1'b1, 2'b10, 1'b0, 32'h60, 32'hDEADBEEF, 1'b0, 32'h0);
      bus_if.req_valid = 1'b1; bus_if.req_write = wv.wr; bus_if.req_size = wv.size;
      bus_if.req_unsigned = wv.uns; bus_if.req_addr = wv.addr; bus_if.req_wdata = wv.wdata;
      @(posedge clock);
      #1 bus_if.req_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      #1 chk("midrst strobes", {30'h0, bus_if.mem_read, bus_if.mem_write}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("midrst req_ready", {31'h0, bus_if.req_ready}, 32'h1);
      repeat (3) @(negedge clock);
      chk("midrst no_resp", resp_cnt - resp0, 0);
      chk("midrst mem60", {24'h0, mem[8'h60]}, 32'hDE);
      chk("midrst mem61", {24'h0, mem[8'h61]}, 32'hAD);
      chk("midrst mem62", {24'h0, mem[8'h62]}, 32'h00);
      chk("midrst mem63", {24'h0, mem[8'h63]}, 32'h00);
      chk("never_both_strobes", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
